// File: rtl/bus_sel_pkg.sv
// Shared definitions for the bus select encoder: default sizes, the
// priority-direction and handshake-state enums, and a multi-hot test helper.
package bus_sel_pkg;

    localparam int DEFAULT_N     = 32;
    localparam int DEFAULT_CNT_W = 8;
    localparam int MAX_N         = 256;

    typedef enum logic {
        PRIO_LSB_FIRST = 1'b0,
        PRIO_MSB_FIRST = 1'b1
    } prio_dir_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Clearing the lowest set bit leaves something behind only when at least
    // two bits were set, so this is "popcount > 1" without an adder tree.
    function automatic logic isMultiHot(input logic [MAX_N-1:0] vec);
        return |(vec & (vec - MAX_N'(1)));
    endfunction

endpackage

// File: rtl/bus_sel_encoder_ffs_enc.sv
// Combinational find-first-set encoder.
// MSB_FIRST=0 scans upward starting at start_i and wraps from N-1 to 0.
// MSB_FIRST=1 picks the highest set bit and ignores start_i.
module ffs_enc #(
    parameter int N         = 32,
    parameter int MSB_FIRST = 0,
    parameter int W         = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] start_i,
    output logic [W-1:0] idx_o,
    output logic [N-1:0] onehot_o,
    output logic         none_o
);

    // Position visited at scan step k. Step 0 is the highest-priority position.
    function automatic int scanPos(input int base, input int k);
        int p;
        if (MSB_FIRST != 0) begin
            p = N - 1 - k;
        end else begin
            p = base + k;
            if (p >= N) p = p - N;
        end
        return p;
    endfunction

    // Walk from the lowest-priority position to the highest. The last match
    // overwrites earlier ones, so the winner needs no "found" chain.
    always_comb begin
        idx_o    = '0;
        onehot_o = '0;
        none_o   = 1'b1;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[scanPos(int'(start_i), k)]) begin
                idx_o    = W'(scanPos(int'(start_i), k));
                onehot_o = '0;
                onehot_o[scanPos(int'(start_i), k)] = 1'b1;
                none_o   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bus_sel_encoder.sv
// Registered one-hot/priority encoder for bus-driver select vectors.
// The output register has one stage and uses a valid/ready handshake.
// Multi-hot selects are flagged and counted.
// Optional macro BUS_SEL_ROUND_ROBIN_EN enables a rotating search start
// pointer. When it is enabled, MSB_FIRST is ignored.
module bus_sel_encoder
    import bus_sel_pkg::*;
#(
    parameter int N         = DEFAULT_N,
    parameter int W         = $clog2(N),
    parameter int MSB_FIRST = 0,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_idx,
    output logic [N-1:0]     out_onehot,
    output logic             out_none,
    output logic             out_multi,
    input  logic             err_clr,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

`ifdef BUS_SEL_ROUND_ROBIN_EN
    localparam prio_dir_e ENC_DIR = PRIO_LSB_FIRST;
`else
    localparam prio_dir_e ENC_DIR = (MSB_FIRST != 0) ? PRIO_MSB_FIRST : PRIO_LSB_FIRST;
`endif

    state_e           state_q;
    logic [W-1:0]     outIdx_q;
    logic [N-1:0]     outOnehot_q;
    logic             outNone_q;
    logic             outMulti_q;
    logic             errSticky_q, errSticky_d;
    logic [CNT_W-1:0] errCount_q, errCount_d;

    logic             accept;
    logic             reqMulti;
    logic [W-1:0]     searchStart;
    logic [W-1:0]     encIdx;
    logic [N-1:0]     encOnehot;
    logic             encNone;

    assign out_valid  = (state_q == FULL);
    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign reqMulti   = isMultiHot(MAX_N'(req));

    assign out_idx    = outIdx_q;
    assign out_onehot = outOnehot_q;
    assign out_none   = outNone_q;
    assign out_multi  = outMulti_q;
    assign err_sticky = errSticky_q;
    assign err_count  = errCount_q;

`ifdef BUS_SEL_ROUND_ROBIN_EN
    logic [W-1:0] ptr_q, ptr_d;

    assign searchStart = ptr_q;

    // Move the pointer just past the last winner so the next search starts
    // one position higher. Compare against N-1 so non-power-of-2 N wraps.
    always_comb begin
        ptr_d = ptr_q;
        if (accept && !encNone) begin
            ptr_d = (encIdx == W'(N - 1)) ? '0 : encIdx + W'(1);
        end
    end

    // Register the round-robin pointer.
    always_ff @(posedge clk) begin
        if (clr) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`else
    assign searchStart = '0;
`endif

    ffs_enc #(
        .N         (N),
        .MSB_FIRST ((ENC_DIR == PRIO_MSB_FIRST) ? 1 : 0),
        .W         (W)
    ) u_ffs (
        .req_i    (req),
        .start_i  (searchStart),
        .idx_o    (encIdx),
        .onehot_o (encOnehot),
        .none_o   (encNone)
    );

    // Error bookkeeping changes only on accepted multi-hot selects. Such an
    // event takes priority over a clear that arrives in the same cycle.
    always_comb begin
        errSticky_d = errSticky_q;
        errCount_d  = errCount_q;
        if (accept && reqMulti) begin
            errSticky_d = 1'b1;
            if (err_clr)                   errCount_d = CNT_W'(1);
            else if (errCount_q != CNT_MAX) errCount_d = errCount_q + CNT_W'(1);
        end else if (err_clr) begin
            errSticky_d = 1'b0;
            errCount_d  = '0;
        end
    end

    // Register the error sticky flag and the saturating error count.
    always_ff @(posedge clk) begin
        if (clr) begin
            errSticky_q <= 1'b0;
            errCount_q  <= '0;
        end else begin
            errSticky_q <= errSticky_d;
            errCount_q  <= errCount_d;
        end
    end

    // EMPTY/FULL handshake FSM plus the result register. A new select is
    // captured on every accept, including a back-to-back accept while FULL.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= EMPTY;
            outIdx_q    <= '0;
            outOnehot_q <= '0;
            outNone_q   <= 1'b0;
            outMulti_q  <= 1'b0;
        end else begin
            case (state_q)
                EMPTY:   if (accept) state_q <= FULL;
                FULL:    if (out_ready && !in_valid) state_q <= EMPTY;
                default: state_q <= EMPTY;
            endcase
            if (accept) begin
                outIdx_q    <= encIdx;
                outOnehot_q <= encOnehot;
                outNone_q   <= encNone;
                outMulti_q  <= reqMulti;
            end
        end
    end

endmodule

// File: tb/tb_bus_sel_encoder.sv
// Testbench for bus_sel_encoder.
// It runs three instances side by side:
//   N=32, lowest bit wins, CNT_W=4
//   N=32, highest bit wins, CNT_W=8
//   N=5,  lowest bit wins, CNT_W=8
// All three are checked against a behavioural reference model.
// Honours BUS_SEL_ROUND_ROBIN_EN when that macro is defined.
module tb_bus_sel_encoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        clr, inValid, outReady, errClr;
   logic [31:0] reqA;
   logic [4:0]  reqC;

   logic        inReadyA, outValidA, noneA, multiA, stickyA;
   logic [4:0]  idxA;
   logic [31:0] oneA;
   logic [3:0]  cntA;

   logic        inReadyB, outValidB, noneB, multiB, stickyB;
   logic [4:0]  idxB;
   logic [31:0] oneB;
   logic [7:0]  cntB;

   logic        inReadyC, outValidC, noneC, multiC, stickyC;
   logic [2:0]  idxC;
   logic [4:0]  oneC;
   logic [7:0]  cntC;

   bus_sel_encoder #(.N(32), .MSB_FIRST(0), .CNT_W(4)) dutA (
      .clk(clk), .clr(clr), .in_valid(inValid), .in_ready(inReadyA), .req(reqA),
      .out_valid(outValidA), .out_ready(outReady), .out_idx(idxA), .out_onehot(oneA),
      .out_none(noneA), .out_multi(multiA), .err_clr(errClr), .err_sticky(stickyA),
      .err_count(cntA));

   bus_sel_encoder #(.N(32), .MSB_FIRST(1), .CNT_W(8)) dutB (
      .clk(clk), .clr(clr), .in_valid(inValid), .in_ready(inReadyB), .req(reqA),
      .out_valid(outValidB), .out_ready(outReady), .out_idx(idxB), .out_onehot(oneB),
      .out_none(noneB), .out_multi(multiB), .err_clr(errClr), .err_sticky(stickyB),
      .err_count(cntB));

   bus_sel_encoder #(.N(5), .MSB_FIRST(0), .CNT_W(8)) dutC (
      .clk(clk), .clr(clr), .in_valid(inValid), .in_ready(inReadyC), .req(reqC),
      .out_valid(outValidC), .out_ready(outReady), .out_idx(idxC), .out_onehot(oneC),
      .out_none(noneC), .out_multi(multiC), .err_clr(errClr), .err_sticky(stickyC),
      .err_count(cntC));

`ifdef BUS_SEL_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   int checkCount = 0;
   int passCount  = 0;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference model, per instance: request width, priority direction and
   // saturation limit, plus the expected register contents.
   int          nOf[3]   = '{32, 32, 5};
   int          msbOf[3] = '{0, 1, 0};
   int          maxOf[3] = '{15, 255, 255};
   bit          mValid[3], mNone[3], mMulti[3], mSticky[3];
   int          mIdx[3], mCount[3], mPtr[3];
   logic [31:0] mOne[3];
   bit          started = 1'b0;

   // Winning position under the priority rules, or -1 when no bit is set.
   function automatic int winner(input int n, input logic [31:0] r, input int msb, input int start);
      for (int k = 0; k < n; k++) begin
         int p;
         p = (msb != 0) ? (n - 1 - k) : ((start + k) % n);
         if (r[p]) return p;
      end
      return -1;
   endfunction

   // Advance the model on each clock edge using the inputs seen at that edge.
   always @(posedge clk) begin : modelUpdate
      logic [31:0] r;
      bit          acc, multiEvt;
      int          w;
      started = 1'b1;
      for (int i = 0; i < 3; i++) begin
         r = (i == 2) ? {27'b0, reqC} : reqA;
         if (clr) begin
            mValid[i] = 0; mIdx[i] = 0; mOne[i] = 0; mNone[i] = 0; mMulti[i] = 0;
            mSticky[i] = 0; mCount[i] = 0; mPtr[i] = 0;
         end else begin
            acc      = inValid && (!mValid[i] || outReady);
            multiEvt = acc && ($countones(r) > 1);
            if (acc) begin
               w = winner(nOf[i], r, RR ? 0 : msbOf[i], RR ? mPtr[i] : 0);
               mValid[i] = 1;
               mIdx[i]   = (w < 0) ? 0 : w;
               mOne[i]   = (w < 0) ? 32'd0 : (32'd1 << w);
               mNone[i]  = (r == 0);
               mMulti[i] = ($countones(r) > 1);
               if (RR && w >= 0) mPtr[i] = (w + 1) % nOf[i];
            end else if (mValid[i] && outReady) begin
               mValid[i] = 0;
            end
            if (multiEvt) begin
               mSticky[i] = 1;
               mCount[i]  = errClr ? 1 : ((mCount[i] < maxOf[i]) ? mCount[i] + 1 : mCount[i]);
            end else if (errClr) begin
               mSticky[i] = 0;
               mCount[i]  = 0;
            end
         end
      end
   end

   // Compare one instance's outputs with the model. Result fields are only
   // compared while a result is being held.
   task automatic compareInst(input int i, input logic ov, input logic ir, input logic [31:0] idx,
                              input logic [31:0] one, input logic none, input logic multi,
                              input logic sticky, input logic [31:0] cnt);
      checkOutput($sformatf("inst%0d out_valid", i), ov, mValid[i]);
      checkOutput($sformatf("inst%0d in_ready", i), ir, !mValid[i] || outReady);
      checkOutput($sformatf("inst%0d err_sticky", i), sticky, mSticky[i]);
      checkOutput($sformatf("inst%0d err_count", i), cnt, mCount[i]);
      if (mValid[i]) begin
         checkOutput($sformatf("inst%0d out_idx", i), idx, mIdx[i]);
         checkOutput($sformatf("inst%0d out_onehot", i), one, mOne[i]);
         checkOutput($sformatf("inst%0d out_none", i), none, mNone[i]);
         checkOutput($sformatf("inst%0d out_multi", i), multi, mMulti[i]);
      end
   endtask

   // Check every instance against the model on each falling edge.
   always @(negedge clk) begin
      if (started) begin
         compareInst(0, outValidA, inReadyA, {27'b0, idxA}, oneA, noneA, multiA, stickyA, {28'b0, cntA});
         compareInst(1, outValidB, inReadyB, {27'b0, idxB}, oneB, noneB, multiB, stickyB, {24'b0, cntB});
         compareInst(2, outValidC, inReadyC, {29'b0, idxC}, {27'b0, oneC}, noneC, multiC, stickyC, {24'b0, cntC});
      end
   end

   // Drive one cycle of inputs just after the falling edge.
   task automatic applyStimulus(input logic c, input logic iv, input logic [31:0] ra,
                                input logic [4:0] rc, input logic ordy, input logic ec);
      @(negedge clk);
      #1;
      clr = c; inValid = iv; reqA = ra; reqC = rc; outReady = ordy; errClr = ec;
   endtask

   // Wait until just after the edge that samples the driven inputs.
   task automatic waitResult();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not complete");
      $fatal(1, "[TB] timeout");
   end

   initial begin
`ifdef BUS_SEL_ROUND_ROBIN_EN
      int rrA[3] = '{0, 4, 0};
      int rrB[3] = '{0, 4, 0};
      int rrC[3] = '{0, 4, 0};
`else
      int rrA[3] = '{0, 0, 0};
      int rrB[3] = '{4, 4, 4};
      int rrC[3] = '{0, 0, 0};
`endif
      clr = 1'b1; inValid = 1'b0; reqA = '0; reqC = '0; outReady = 1'b0; errClr = 1'b0;

      // Reset state.
      applyStimulus(1, 0, 0, 0, 0, 0);
      waitResult();
      checkOutput("reset out_valid", outValidA, 0);
      checkOutput("reset err_count", cntA, 0);
      checkOutput("reset out_idx", idxA, 0);

      // Single one-hot select.
      applyStimulus(0, 1, 32'h0000_0400, 5'b00100, 1, 0);
      waitResult();
      checkOutput("onehot out_valid", outValidA, 1);
      checkOutput("onehot idxA", idxA, 10);
      checkOutput("onehot oneA", oneA, 32'h0000_0400);
      checkOutput("onehot multiA", multiA, 0);
      checkOutput("onehot noneA", noneA, 0);
      checkOutput("onehot idxB", idxB, 10);
      checkOutput("onehot idxC", idxC, 2);

      // All-zero select.
      applyStimulus(0, 1, 0, 0, 1, 0);
      waitResult();
      checkOutput("zero idxA", idxA, 0);
      checkOutput("zero oneA", oneA, 0);
      checkOutput("zero noneA", noneA, 1);
      checkOutput("zero cntA", cntA, 0);

      // Multi-hot select, resolved by each instance's priority direction.
      applyStimulus(0, 1, 32'h8000_0001, 5'b10001, 1, 0);
      waitResult();
`ifndef BUS_SEL_ROUND_ROBIN_EN
      checkOutput("multi idxA", idxA, 0);
      checkOutput("multi idxB", idxB, 31);
      checkOutput("multi idxC", idxC, 0);
`endif
      checkOutput("multi multiA", multiA, 1);
      checkOutput("multi stickyA", stickyA, 1);
      checkOutput("multi cntA", cntA, 1);
      checkOutput("multi cntB", cntB, 1);

      // Backpressure: hold a result while a multi-hot select waits at the input.
      applyStimulus(0, 1, 32'h0000_0020, 5'b00010, 1, 0);
      waitResult();
`ifndef BUS_SEL_ROUND_ROBIN_EN
      checkOutput("bp first idxA", idxA, 5);
`endif
      for (int c = 0; c < 3; c++) begin
         applyStimulus(0, 1, 32'h0000_1010, 5'b01010, 0, 0);
         waitResult();
         checkOutput("bp in_ready", inReadyA, 0);
         checkOutput("bp held valid", outValidA, 1);
         checkOutput("bp held cnt", cntA, 1);
`ifndef BUS_SEL_ROUND_ROBIN_EN
         checkOutput("bp held idxA", idxA, 5);
`endif
      end
      applyStimulus(0, 1, 32'h0000_1010, 5'b01010, 1, 0);
      waitResult();
`ifndef BUS_SEL_ROUND_ROBIN_EN
      checkOutput("bp release idxA", idxA, 4);
      checkOutput("bp release idxB", idxB, 12);
      checkOutput("bp release idxC", idxC, 1);
`endif
      checkOutput("bp release cnt", cntA, 2);
      applyStimulus(0, 0, 0, 0, 1, 0);
      waitResult();
      checkOutput("drain out_valid", outValidA, 0);

      // Saturation of the error counter, then clear behaviour.
      for (int k = 0; k < 20; k++) applyStimulus(0, 1, 32'h0000_0003, 5'b00011, 1, 0);
      waitResult();
      checkOutput("sat cntA", cntA, 15);
      checkOutput("sat cntB", cntB, 22);
      checkOutput("sat cntC", cntC, 22);
      applyStimulus(0, 1, 32'h0000_0003, 5'b00011, 1, 1);
      waitResult();
      checkOutput("clr+event cntA", cntA, 1);
      checkOutput("clr+event stickyA", stickyA, 1);
      checkOutput("clr+event cntB", cntB, 1);
      applyStimulus(0, 0, 0, 0, 1, 1);
      waitResult();
      checkOutput("clr only cntA", cntA, 0);
      checkOutput("clr only stickyA", stickyA, 0);

      // Rotating start (round-robin builds) or fixed priority (default builds).
      applyStimulus(1, 0, 0, 0, 1, 0);
      waitResult();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 1, 32'h0000_0011, 5'b10001, 1, 0);
         waitResult();
         checkOutput($sformatf("rot%0d idxA", k), idxA, rrA[k]);
         checkOutput($sformatf("rot%0d idxB", k), idxB, rrB[k]);
         checkOutput($sformatf("rot%0d idxC", k), idxC, rrC[k]);
      end
      applyStimulus(0, 1, 32'h0000_0011, 5'b10001, 1, 0);
      applyStimulus(1, 1, 32'h0000_0011, 5'b10001, 1, 0);
      waitResult();
      checkOutput("midclr out_valid", outValidA, 0);
      applyStimulus(0, 1, 32'h0000_0011, 5'b10001, 1, 0);
      waitResult();
      checkOutput("postclr idxA", idxA, 0);
      checkOutput("postclr idxC", idxC, 0);

      applyStimulus(0, 0, 0, 0, 1, 0);
      waitResult();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
